// File: rtl/sift_kp_pkg.sv
// Shared types and constants for the SIFT keypoint collector.
// The default keypoint FIFO entry layout, from MSB to LSB, is {frame, y, x}.
// The frame field exists only when KP_FRAME_ID_EN is defined.
package sift_kp_pkg;

    localparam int FRAME_ID_W = 8;
    localparam int DEF_X_W    = 10;
    localparam int DEF_Y_W    = 9;
    localparam int DEF_CNT_W  = 16;

    // Entry layout at the default image geometry.
    typedef struct packed {
        logic [FRAME_ID_W-1:0] frame;
        logic [DEF_Y_W-1:0]    y;
        logic [DEF_X_W-1:0]    x;
    } kp_entry_t;

endpackage

// File: rtl/sift_kp_fifo.sv
// kp_fifo: synchronous show-ahead FIFO for keypoint entries.
// The head entry is always presented on data_o. A push into an empty FIFO
// becomes visible on the cycle after the push.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (pointers/count only)
//   push_i, data_i   write strobe and entry; caller pushes only if !full or popping
//   pop_i            read strobe; caller pops only if !empty
//   data_o           head entry
//   empty_o, full_o  occupancy flags, derived from the registered count
module kp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 19
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset. Stale entries are never visible because the
    // head is qualified by the empty flag.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/sift_kp_collector.sv
// sift_kp_collector: tracks the pixel position from the DoG pixel strobe,
// border-masks the extremum flag, and buffers accepted keypoint coordinates
// in a show-ahead FIFO. It also keeps per-frame accepted and dropped
// counters, and both counters saturate.
// Optional feature: define KP_FRAME_ID_EN to store an 8-bit frame id with
// each entry. When the macro is undefined, okp_frame is tied to 0.
// Ports:
//   iclk, irst                  clock, synchronous active-high reset
//   ivalid, iframe_start        pixel strobe, frame start (qualified by ivalid)
//   iextrema                    extremum flag of the current pixel
//   iread                       pop the head entry (ignored when empty)
//   okp_valid/okp_x/okp_y/okp_frame  head entry (zero when empty)
//   ofifo_full                  FIFO occupancy == FIFO_DEPTH
//   okp_count, odrop_cnt        per-frame accepted / dropped keypoints
module sift_kp_collector
    import sift_kp_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int BORDER     = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  ivalid,
    input  logic                  iframe_start,
    input  logic                  iextrema,
    input  logic                  iread,
    output logic                  okp_valid,
    output logic [X_W-1:0]        okp_x,
    output logic [Y_W-1:0]        okp_y,
    output logic [FRAME_ID_W-1:0] okp_frame,
    output logic                  ofifo_full,
    output logic [CNT_W-1:0]      okp_count,
    output logic [CNT_W-1:0]      odrop_cnt
);
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);
    localparam logic [X_W-1:0] X_LO   = X_W'(BORDER);
    localparam logic [X_W-1:0] X_HI   = X_W'(IMG_W - 1 - BORDER);
    localparam logic [Y_W-1:0] Y_LO   = Y_W'(BORDER);
    localparam logic [Y_W-1:0] Y_HI   = Y_W'(IMG_H - 1 - BORDER);
`ifdef KP_FRAME_ID_EN
    localparam int ENTRY_W = FRAME_ID_W + Y_W + X_W;
`else
    localparam int ENTRY_W = Y_W + X_W;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    logic [X_W-1:0]     x_q, x_d, cur_x;
    logic [Y_W-1:0]     y_q, y_d, cur_y;
    logic [CNT_W-1:0]   kp_cnt_q, kp_cnt_d, drop_q, drop_d;
    logic               fs, accept, push, pop, drop, empty, full;
    logic [ENTRY_W-1:0] entry, head;

    // A frame-start pixel is (0,0) regardless of where the counters were.
    assign fs    = ivalid & iframe_start;
    assign cur_x = fs ? '0 : x_q;
    assign cur_y = fs ? '0 : y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (ivalid) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    assign accept = ivalid & iextrema &
                    (cur_x >= X_LO) & (cur_x <= X_HI) &
                    (cur_y >= Y_LO) & (cur_y <= Y_HI);
    assign pop    = iread & ~empty;
    // When the FIFO is full, a same-cycle pop frees the slot for this push.
    assign push   = accept & (~full | pop);
    assign drop   = accept & ~push;

    // The frame-start pixel's own event counts from a cleared counter.
    always_comb begin
        kp_cnt_d = sat_inc(fs ? '0 : kp_cnt_q, push);
        drop_d   = sat_inc(fs ? '0 : drop_q, drop);
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            x_q      <= '0;
            y_q      <= '0;
            kp_cnt_q <= '0;
            drop_q   <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            kp_cnt_q <= kp_cnt_d;
            drop_q   <= drop_d;
        end
    end

`ifdef KP_FRAME_ID_EN
    logic [FRAME_ID_W-1:0] fid_q, fid_cur;

    // The entry pushed on a frame-start cycle carries the new id.
    assign fid_cur = fs ? fid_q + 1'b1 : fid_q;

    always_ff @(posedge iclk) begin
        if (irst) fid_q <= '0;
        else      fid_q <= fid_cur;
    end

    assign entry     = {fid_cur, cur_y, cur_x};
    assign okp_frame = empty ? '0 : head[X_W+Y_W +: FRAME_ID_W];
`else
    assign entry     = {cur_y, cur_x};
    assign okp_frame = '0;
`endif

    kp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (iclk),
        .rst_i   (irst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (entry),
        .data_o  (head),
        .empty_o (empty),
        .full_o  (full)
    );

    assign okp_valid  = ~empty;
    assign okp_x      = empty ? '0 : head[X_W-1:0];
    assign okp_y      = empty ? '0 : head[X_W +: Y_W];
    assign ofifo_full = full;
    assign okp_count  = kp_cnt_q;
    assign odrop_cnt  = drop_q;

endmodule

// File: tb/tb_sift_kp_collector.sv
module tb_sift_kp_collector;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int B  = 1;
    localparam int D  = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          iclk = 1'b0;
    logic          irst = 1'b1;
    logic          ivalid = 1'b0, iframe_start = 1'b0, iextrema = 1'b0, iread = 1'b0;
    logic          okp_valid, ofifo_full;
    logic [2:0]    okp_x, okp_y;
    logic [7:0]    okp_frame;
    logic [CW-1:0] okp_count, odrop_cnt;

    always #5 iclk = ~iclk;

    sift_kp_collector #(
        .IMG_W(W), .IMG_H(H), .X_W(3), .Y_W(3), .BORDER(B),
        .FIFO_DEPTH(D), .CNT_W(CW)
    ) dut (
        .iclk(iclk), .irst(irst), .ivalid(ivalid), .iframe_start(iframe_start),
        .iextrema(iextrema), .iread(iread), .okp_valid(okp_valid),
        .okp_x(okp_x), .okp_y(okp_y), .okp_frame(okp_frame),
        .ofifo_full(ofifo_full), .okp_count(okp_count), .odrop_cnt(odrop_cnt)
    );

    typedef struct { int x; int y; int f; } kp_t;
    kp_t sb[$];   // expected readout stream, oldest first

    // Reference model state: pixel index within the frame, FIFO occupancy,
    // per-frame counters, frame id.
    int m_pos = 0, m_occ = 0, m_kc = 0, m_dc = 0, m_fid = 0;
    bit exp_set = 0, exp_valid = 0, exp_full = 0;
    int exp_kc = 0, exp_dc = 0;
    int n_cmp = 0, n_bad = 0;

    function automatic void chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Drive one cycle's inputs and advance the model to the state expected
    // after the next rising edge.
    task automatic step(input bit v, input bit fs, input bit ex, input bit rd, input bit rst);
        bit pop, acc;
        int x, y;
        @(negedge iclk);
        #2;
        ivalid = v; iframe_start = fs; iextrema = ex; iread = rd; irst = rst;
        if (rst) begin
            m_pos = 0; m_occ = 0; m_kc = 0; m_dc = 0; m_fid = 0;
            sb.delete();
        end else begin
            pop = rd && (m_occ > 0);
            if (v && fs) begin
                m_pos = 0; m_kc = 0; m_dc = 0;
                m_fid = (m_fid + 1) % 256;
            end
            if (v) begin
                x = m_pos % W;
                y = m_pos / W;
                acc = ex && x >= B && x <= W - 1 - B && y >= B && y <= H - 1 - B;
                if (acc) begin
                    if (m_occ < D || pop) begin
                        kp_t e;
                        e.x = x; e.y = y;
`ifdef KP_FRAME_ID_EN
                        e.f = m_fid;
`else
                        e.f = 0;
`endif
                        sb.push_back(e);
                        m_occ++;
                        if (m_kc < CMAX) m_kc++;
                    end else if (m_dc < CMAX) begin
                        m_dc++;
                    end
                end
                m_pos = (m_pos + 1) % (W * H);
            end
            if (pop) m_occ--;
        end
        exp_valid = (m_occ > 0);
        exp_full  = (m_occ == D);
        exp_kc    = m_kc;
        exp_dc    = m_dc;
        exp_set   = 1;
    endtask

    task automatic segment(input int n, input bit start_fs, input int pv,
                           input int pfs_permille, input int pex, input int prd);
        for (int i = 0; i < n; i++) begin
            bit v, fs, ex, rd;
            v  = ($urandom_range(99) < pv);
            fs = v && ($urandom_range(999) < pfs_permille);
            if (i == 0 && start_fs) begin v = 1; fs = 1; end
            ex = ($urandom_range(99) < pex);
            rd = ($urandom_range(99) < prd);
            step(v, fs, ex, rd, 1'b0);
        end
    endtask

    // Status monitor: registered outputs just after each rising edge.
    always @(posedge iclk) begin
        #1;
        if (exp_set) begin
            chk("okp_valid", okp_valid, exp_valid);
            chk("ofifo_full", ofifo_full, exp_full);
            chk("okp_count", okp_count, exp_kc);
            chk("odrop_cnt", odrop_cnt, exp_dc);
            if (!exp_valid) begin
                chk("idle_x", okp_x, 0);
                chk("idle_y", okp_y, 0);
                chk("idle_frame", okp_frame, 0);
            end
        end
    end

    // Readout monitor: a pop is about to happen, so compare the head with
    // the oldest expected entry.
    always @(negedge iclk) begin
        #3;
        if (!irst && iread && okp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_head", 1, 0);
            end else begin
                kp_t e;
                e = sb.pop_front();
                chk("head_x", okp_x, e.x);
                chk("head_y", okp_y, e.y);
                chk("head_frame", okp_frame, e.f);
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        segment(400, 1, 90, 0, 40, 40);   // long run: wraps, counter saturation
        segment(200, 0, 80, 0, 70, 0);    // no reads: fill, overflow, drops
        segment(150, 0, 80, 0, 60, 25);   // near full: push with pop at full
        segment(120, 0, 70, 5, 30, 60);   // random frame starts
        step(1, 0, 1, 1, 1);              // reset mid-stream
        step(1, 1, 1, 1, 1);
        segment(300, 0, 85, 3, 40, 35);   // resync from (0,0) without frame start
        segment(150, 1, 90, 8, 50, 50);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        @(negedge iclk);
        chk("stream_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
